reg_writeback: RTL and testbench

Write-back stage driving the register file write port (write_enable, rd_addr, rd_data). Merges single-cycle ALU results with in-order, multi-cycle load responses, sign/zero-extends load data, tracks destination registers of outstanding loads in a scoreboard, and reports read-after-write and write-after-write hazards to decode.

---
 rtl/reg_writeback.sv | 212 +++++++++++++++++++++
 tb/tb_reg_writeback.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Write-back stage: merges ALU results and in-order load responses into the regfile port.
// Define REG_WB_FORWARD_EN to add fwd1/fwd2 bypass outputs instead of stalling on the in-flight write.
module reg_writeback #(
  parameter int LOAD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        load_issue_valid,
  output logic        load_issue_ready,
  input  logic [4:0]  load_issue_rd,
  input  logic [2:0]  load_issue_funct3,
  input  logic [1:0]  load_issue_offset,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_query,
  output logic        hazard,
`ifdef REG_WB_FORWARD_EN
  output logic        fwd1_valid,
  output logic [31:0] fwd1_data,
  output logic        fwd2_valid,
  output logic [31:0] fwd2_data,
`endif
  output logic        write_enable,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data
);

  localparam int PW = $clog2(LOAD_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    q_rd_q  [LOAD_DEPTH];
  logic [4:0]    q_rd_d  [LOAD_DEPTH];
  logic [2:0]    q_f3_q  [LOAD_DEPTH];
  logic [2:0]    q_f3_d  [LOAD_DEPTH];
  logic [1:0]    q_off_q [LOAD_DEPTH];
  logic [1:0]    q_off_d [LOAD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   pending_q, pending_d;

  logic          hold_valid_q, hold_valid_d;
  logic [4:0]    hold_rd_q, hold_rd_d;
  logic [31:0]   hold_data_q, hold_data_d;

  logic          we_q, we_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   rd_data_q, rd_data_d;

  logic          q_empty;
  logic          q_full;
  logic          push;
  logic          accept;
  logic          pop;
  logic [31:0]   load_val;
  logic [4:0]    head_rd;
  logic          clr_en;
  logic [4:0]    clr_rd;
  logic          inflight_hit;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  assign q_empty          = (count_q == '0);
  assign q_full           = (count_q == CW'(LOAD_DEPTH));
  assign load_issue_ready = !q_full;
  assign mem_rready       = !hold_valid_q;
  assign push             = load_issue_valid && load_issue_ready;
  assign accept           = mem_rvalid && mem_rready;
  assign pop              = accept && !q_empty;
  assign head_rd          = q_rd_q[rd_ptr_q];
  assign load_val         = extract(mem_rdata, q_f3_q[rd_ptr_q],
                                    q_off_q[rd_ptr_q]);

  always_comb begin
    q_rd_d       = q_rd_q;
    q_f3_d       = q_f3_q;
    q_off_d      = q_off_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;
    we_d         = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    clr_en       = 1'b0;
    clr_rd       = 5'd0;
    pending_d    = pending_q;

    if (push) begin
      q_rd_d[wr_ptr_q]  = load_issue_rd;
      q_f3_d[wr_ptr_q]  = load_issue_funct3;
      q_off_d[wr_ptr_q] = load_issue_offset;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // ALU always wins; a response that loses parks in the hold slot
    if (alu_valid) begin
      if (alu_rd != 5'd0) begin
        we_d      = 1'b1;
        rd_addr_d = alu_rd;
        rd_data_d = alu_data;
      end
      if (pop) begin
        hold_valid_d = 1'b1;
        hold_rd_d    = head_rd;
        hold_data_d  = load_val;
      end
    end else if (hold_valid_q) begin
      hold_valid_d = 1'b0;
      clr_en       = 1'b1;
      clr_rd       = hold_rd_q;
      if (hold_rd_q != 5'd0) begin
        we_d      = 1'b1;
        rd_addr_d = hold_rd_q;
        rd_data_d = hold_data_q;
      end
    end else if (pop) begin
      clr_en = 1'b1;
      clr_rd = head_rd;
      if (head_rd != 5'd0) begin
        we_d      = 1'b1;
        rd_addr_d = head_rd;
        rd_data_d = load_val;
      end
    end

    if (clr_en) pending_d[clr_rd] = 1'b0;
    if (push)   pending_d[load_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOAD_DEPTH; i++) begin
        q_rd_q[i]  <= '0;
        q_f3_q[i]  <= '0;
        q_off_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
      we_q         <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      q_rd_q       <= q_rd_d;
      q_f3_q       <= q_f3_d;
      q_off_q      <= q_off_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
      we_q         <= we_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign write_enable = we_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;

`ifdef REG_WB_FORWARD_EN
  assign fwd1_valid   = we_q && (rd_addr_q != 5'd0) && (rd_addr_q == rs1_addr);
  assign fwd2_valid   = we_q && (rd_addr_q != 5'd0) && (rd_addr_q == rs2_addr);
  assign fwd1_data    = rd_data_q;
  assign fwd2_data    = rd_data_q;
  assign inflight_hit = 1'b0;
`else
  assign inflight_hit = we_q && (rd_addr_q != 5'd0) &&
                        ((rd_addr_q == rs1_addr) || (rd_addr_q == rs2_addr));
`endif

  assign hazard = pending_q[rs1_addr] | pending_q[rs2_addr] |
                  pending_q[rd_query] | inflight_hit;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: scoreboard of expected regfile writes
// plus per-scenario inline checks of handshakes and hazard.
module tb_reg_writeback;

  localparam int LD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        load_issue_valid;
  logic        load_issue_ready;
  logic [4:0]  load_issue_rd;
  logic [2:0]  load_issue_funct3;
  logic [1:0]  load_issue_offset;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_addr, rs2_addr, rd_query;
  logic        hazard;
  logic        write_enable;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef REG_WB_FORWARD_EN
  logic        fwd1_valid, fwd2_valid;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  int checks = 0;
  int errors = 0;
  logic [36:0] expq[$];

  always #5 clk = ~clk;

  reg_writeback #(.LOAD_DEPTH(LD)) dut (
    .clk(clk),
    .rst(rst),
    .alu_valid(alu_valid),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .load_issue_valid(load_issue_valid),
    .load_issue_ready(load_issue_ready),
    .load_issue_rd(load_issue_rd),
    .load_issue_funct3(load_issue_funct3),
    .load_issue_offset(load_issue_offset),
    .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready),
    .mem_rdata(mem_rdata),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rd_query(rd_query),
    .hazard(hazard),
`ifdef REG_WB_FORWARD_EN
    .fwd1_valid(fwd1_valid),
    .fwd1_data(fwd1_data),
    .fwd2_valid(fwd2_valid),
    .fwd2_data(fwd2_data),
`endif
    .write_enable(write_enable),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always @(negedge clk) begin
    if (!rst && write_enable) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: write x%0d=%h, none required",
                 rd_addr, rd_data);
      end else begin
        logic [36:0] e;
        e = expq.pop_front();
        if ({rd_addr, rd_data} !== e) begin
          errors++;
          $display("FAIL sb_write: got x%0d=%h, required x%0d=%h",
                   rd_addr, rd_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    expq.push_back({a, d});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    load_issue_valid = 0; load_issue_rd = 0;
    load_issue_funct3 = 0; load_issue_offset = 0;
    mem_rvalid = 0; mem_rdata = 0;
    rs1_addr = 0; rs2_addr = 0; rd_query = 0;
    tick(); tick();
    checks++;
    if ({write_enable, rd_addr, rd_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_wr: got %b/%0d/%h, required 0/0/0",
               write_enable, rd_addr, rd_data);
    end
    checks++;
    if ({load_issue_ready, mem_rready, hazard} !== 3'b110) begin
      errors++;
      $display("FAIL reset_hs: got rdy=%b rrdy=%b hz=%b, required 1 1 0",
               load_issue_ready, mem_rready, hazard);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    expect_wr(5, 32'hDEADBEEF);
    tick();
    alu_valid = 0;
    checks++;
    if ({write_enable, rd_addr, rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL alu_write: got %b/%0d/%h, required 1/5/deadbeef",
               write_enable, rd_addr, rd_data);
    end
    tick();
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("FAIL alu_one_cycle: got we=%b, required 0", write_enable);
    end
    alu_valid = 1; alu_rd = 0; alu_data = 32'h12345678;
    tick();
    alu_valid = 0;
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("FAIL alu_x0: got we=%b, required 0", write_enable);
    end
    tick();
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] off);
    load_issue_valid = 1; load_issue_rd = rd;
    load_issue_funct3 = f3; load_issue_offset = off;
    tick();
    load_issue_valid = 0;
  endtask

  task automatic test_load_extract();
    issue(7, 3'b000, 2'd3);
    rd_query = 7;
    #1;
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL lb_pending: got hz=%b, required 1", hazard);
    end
    mem_rvalid = 1; mem_rdata = 32'h80FFFFFF;
    expect_wr(7, 32'hFFFFFF80);
    tick();
    mem_rvalid = 0;
    checks++;
    if ({write_enable, rd_data, hazard} !== {1'b1, 32'hFFFFFF80, 1'b0}) begin
      errors++;
      $display("FAIL lb_ext: got we=%b d=%h hz=%b, required 1 ffffff80 0",
               write_enable, rd_data, hazard);
    end
    rd_query = 0;
    issue(8, 3'b101, 2'd2);
    mem_rvalid = 1; mem_rdata = 32'h80FFFFFF;
    expect_wr(8, 32'h000080FF);
    tick();
    mem_rvalid = 0;
    checks++;
    if ({write_enable, rd_addr, rd_data} !== {1'b1, 5'd8, 32'h000080FF}) begin
      errors++;
      $display("FAIL lhu_ext: got %b/%0d/%h, required 1/8/000080ff",
               write_enable, rd_addr, rd_data);
    end
    issue(0, 3'b010, 2'd0);
    mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_rvalid = 0;
    checks++;
    if ({write_enable, load_issue_ready} !== 2'b01) begin
      errors++;
      $display("FAIL load_x0: got we=%b rdy=%b, required 0 1",
               write_enable, load_issue_ready);
    end
    tick();
  endtask

  task automatic test_hazard();
    logic exp_hz;
    rs1_addr = 9;
    issue(9, 3'b010, 2'd0);
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL hz_set: got %b, required 1", hazard);
    end
    tick();
    checks++;
    if (hazard !== 1'b1) begin
      errors++;
      $display("FAIL hz_hold: got %b, required 1", hazard);
    end
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    expect_wr(9, 32'hCAFEF00D);
    tick();
    mem_rvalid = 0;
`ifdef REG_WB_FORWARD_EN
    exp_hz = 1'b0;
    checks++;
    if ({fwd1_valid, fwd1_data, fwd2_valid} !== {1'b1, 32'hCAFEF00D, 1'b0}) begin
      errors++;
      $display("FAIL fwd1: got v=%b d=%h v2=%b, required 1 cafef00d 0",
               fwd1_valid, fwd1_data, fwd2_valid);
    end
`else
    exp_hz = 1'b1;
`endif
    checks++;
    if ({write_enable, rd_addr, hazard} !== {1'b1, 5'd9, exp_hz}) begin
      errors++;
      $display("FAIL hz_wb: got we=%b rd=%0d hz=%b, required 1 9 %b",
               write_enable, rd_addr, hazard, exp_hz);
    end
    tick();
    checks++;
    if (hazard !== 1'b0) begin
      errors++;
      $display("FAIL hz_clear: got %b, required 0", hazard);
    end
    rs1_addr = 0;
  endtask

  task automatic test_collision();
    issue(12, 3'b010, 2'd0);
    rd_query = 12;
    mem_rvalid = 1; mem_rdata = 32'hA5A5_0012;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h1100 + i;
      expect_wr(5'(i), 32'h1100 + i);
      if (i == 3) expect_wr(12, 32'hA5A5_0012);
      tick();
      mem_rvalid = 0;
      checks++;
      if ({write_enable, rd_addr, mem_rready, hazard} !==
          {1'b1, 5'(i), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL coll_alu%0d: got we=%b rd=%0d rr=%b hz=%b, required 1 %0d 0 1",
                 i, write_enable, rd_addr, mem_rready, hazard, i);
      end
    end
    alu_valid = 0;
    tick();
    checks++;
    if ({write_enable, rd_addr, rd_data, mem_rready, hazard} !==
        {1'b1, 5'd12, 32'hA5A5_0012, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL coll_drain: got we=%b rd=%0d d=%h rr=%b hz=%b, required 1 12 a5a50012 1 0",
               write_enable, rd_addr, rd_data, mem_rready, hazard);
    end
    rd_query = 0;
    tick();
  endtask

  task automatic test_full();
    issue(20, 3'b010, 2'd0);
    checks++;
    if (load_issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_one: got rdy=%b, required 1", load_issue_ready);
    end
    issue(21, 3'b010, 2'd0);
    checks++;
    if (load_issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got rdy=%b, required 0", load_issue_ready);
    end
    load_issue_valid = 1; load_issue_rd = 22;
    mem_rvalid = 1; mem_rdata = 32'hAAAA0001;
    expect_wr(20, 32'hAAAA0001);
    tick();
    load_issue_valid = 0;
    mem_rdata = 32'hAAAA0002;
    expect_wr(21, 32'hAAAA0002);
    checks++;
    if ({load_issue_ready, rd_addr} !== {1'b1, 5'd20}) begin
      errors++;
      $display("FAIL full_pop: got rdy=%b rd=%0d, required 1 20",
               load_issue_ready, rd_addr);
    end
    tick();
    mem_rvalid = 0;
    tick();
    rd_query = 22;
    #1;
    checks++;
    if ({hazard, load_issue_ready} !== 2'b01) begin
      errors++;
      $display("FAIL full_drop: got hz=%b rdy=%b, required 0 1",
               hazard, load_issue_ready);
    end
    rd_query = 0;
  endtask

  task automatic test_reset_mid();
    issue(25, 3'b010, 2'd0);
    mem_rvalid = 1; mem_rdata = 32'h0000_0025;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    load_issue_valid = 1; load_issue_rd = 26;
    expect_wr(3, 32'h33);
    tick();
    mem_rvalid = 0;
    alu_rd = 4; alu_data = 32'h44;
    load_issue_rd = 27;
    expect_wr(4, 32'h44);
    tick();
    alu_valid = 0; load_issue_valid = 0;
    checks++;
    if ({load_issue_ready, mem_rready, rd_addr} !== {1'b0, 1'b0, 5'd4}) begin
      errors++;
      $display("FAIL mid_state: got rdy=%b rr=%b rd=%0d, required 0 0 4",
               load_issue_ready, mem_rready, rd_addr);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    rs1_addr = 26; rs2_addr = 27; rd_query = 25;
    #1;
    checks++;
    if ({write_enable, rd_addr, rd_data, load_issue_ready, mem_rready, hazard}
        !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got we=%b rd=%0d d=%h rdy=%b rr=%b hz=%b, required 0 0 0 1 1 0",
               write_enable, rd_addr, rd_data, load_issue_ready,
               mem_rready, hazard);
    end
    tick();
    rst = 1'b0;
    rs1_addr = 0; rs2_addr = 0; rd_query = 0;
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_rvalid = 0;
    checks++;
    if ({write_enable, load_issue_ready, mem_rready} !== 3'b011) begin
      errors++;
      $display("FAIL stray_resp: got we=%b rdy=%b rr=%b, required 0 1 1",
               write_enable, load_issue_ready, mem_rready);
    end
    issue(28, 3'b001, 2'd0);
    mem_rvalid = 1; mem_rdata = 32'h0000_8001;
    expect_wr(28, 32'hFFFF_8001);
    tick();
    mem_rvalid = 0;
    checks++;
    if ({write_enable, rd_addr, rd_data} !== {1'b1, 5'd28, 32'hFFFF8001}) begin
      errors++;
      $display("FAIL post_reset_load: got %b/%0d/%h, required 1/28/ffff8001",
               write_enable, rd_addr, rd_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_extract();
    test_hazard();
    test_collision();
    test_full();
    test_reset_mid();
    tick();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d writes outstanding, required 0",
               expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
